// File: rtl/mux_16to1_scan_sequencer.sv
// Scan sequencer for a 16:1 mux. It loads a parallel word, walks the select
// across every position and returns the mux output as a valid/ready/last bit stream.
module mux_16to1_scan_sequencer #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned SEL_W     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] load_data_i,
   output logic [WIDTH-1:0] mux_in_o,
   output logic [SEL_W-1:0] mux_sel_o,
   input  logic             mux_out_i,
   output logic             ser_valid_o,
   input  logic             ser_ready_i,
   output logic             ser_data_o,
   output logic             ser_last_o,
   output logic             busy_o
);

   localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? SEL_W'(0) : SEL_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mux_in_q, mux_in_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             ready_q, ready_d;

   // State and registered handshake outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         mux_in_q <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         mux_in_q <= mux_in_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         ready_q  <= ready_d;
      end
   end

   // Next state; status outputs are precomputed from the next state so they register cleanly.
   always_comb begin
      state_d  = state_q;
      mux_in_d = mux_in_q;
      sel_d    = sel_q;
      unique case (state_q)
         IDLE: begin
            if (load_valid_i) begin
               mux_in_d = load_data_i;
               sel_d    = SEL_START;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (ser_ready_i) begin
               if (sel_q == SEL_END) begin
                  state_d = IDLE;
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - SEL_W'(1);
               end else begin
                  sel_d = sel_q + SEL_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      valid_d = (state_d == SCAN);
      last_d  = (state_d == SCAN) && (sel_d == SEL_END);
      ready_d = (state_d == IDLE);
   end

   assign mux_in_o     = mux_in_q;
   assign mux_sel_o    = sel_q;
   assign ser_valid_o  = valid_q;
   assign ser_last_o   = last_q;
   assign busy_o       = valid_q;
   assign load_ready_o = ready_q;
   // The serial bit passes straight through from the mux with no extra register.
   assign ser_data_o   = mux_out_i;

endmodule
